// File: rtl/i2c_tx_pkg.sv
// Shared constants for the I2C double-buffered transmit controller and its
// counter block.
package i2c_tx_pkg;

  // Counter widths.
  localparam int unsigned TX_WIDTH    = 6;
  localparam int unsigned BURST_WIDTH = 6;

  // Controller compare points: address phase length, byte length and
  // number of data bytes per burst before STOP.
  localparam int unsigned ADDR_BITS   = 7;
  localparam int unsigned BYTE_BITS   = 8;
  localparam int unsigned BURST_LEN   = 2;

endpackage : i2c_tx_pkg

// File: rtl/i2c_up_counter.sv
// Generic synchronous up-counter with a clear input, optional rising-edge
// increment detection and optional saturation at the all-ones value.
module i2c_up_counter #(
  parameter int unsigned WIDTH     = 6,
  parameter bit          EDGE_MODE = 1'b0,  // 0: count every cycle inc is high, 1: count inc rising edges
  parameter bit          SATURATE  = 1'b0   // 0: wrap to zero, 1: stick at all-ones
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] COUNT_MAX = '1;

  logic step;
  logic at_limit;

  generate
    if (EDGE_MODE) begin : g_edge
      logic inc_d;

      // Remember last cycle's request so a held request counts only once;
      // this keeps tracking even while the counter is being cleared.
      always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for every registered signal, so all
        // flops sample pre-edge values regardless of block ordering.
        if (rst) inc_d <= 1'b0;
        else     inc_d <= inc;
      end

      assign step = inc & ~inc_d;
    end else begin : g_level
      assign step = inc;
    end
  endgenerate

  // Only a saturating counter ever refuses a step at its top value.
  assign at_limit = SATURATE && (count == COUNT_MAX);

  // Count register: reset beats clear beats increment.
  always_ff @(posedge clk) begin
    if (rst)                  count <= '0;
    else if (clr)             count <= '0;
    else if (step && !at_limit) count <= count + WIDTH'(1);
  end

endmodule : i2c_up_counter

// File: rtl/i2c_tx_counters.sv
// Bit counter and burst byte counter for the I2C transmit controller.
// tx_count counts shifted bits (level increment, wraps); burst_count counts
// completed data bytes (one count per request edge, saturates).
module i2c_tx_counters #(
  parameter int unsigned TX_WIDTH    = i2c_tx_pkg::TX_WIDTH,
  parameter int unsigned BURST_WIDTH = i2c_tx_pkg::BURST_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tx_reset,
  input  logic                   tx_inc,
  output logic [TX_WIDTH-1:0]    tx_count,
  input  logic                   burst_reset,
  input  logic                   burst_inc,
  output logic [BURST_WIDTH-1:0] burst_count
);

  // Bit counter: one count per clock while tx_inc is high, modulo 2^TX_WIDTH.
  i2c_up_counter #(
    .WIDTH     (TX_WIDTH),
    .EDGE_MODE (1'b0),
    .SATURATE  (1'b0)
  ) u_tx_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (tx_reset),
    .inc   (tx_inc),
    .count (tx_count)
  );

  // Burst counter: one count per burst_inc rising edge, sticks at all-ones.
  i2c_up_counter #(
    .WIDTH     (BURST_WIDTH),
    .EDGE_MODE (1'b1),
    .SATURATE  (1'b1)
  ) u_burst_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (burst_reset),
    .inc   (burst_inc),
    .count (burst_count)
  );

endmodule : i2c_tx_counters

// File: tb/tb_i2c_tx_counters.sv
// Self-checking bench for i2c_tx_counters: directed plan followed by random
// cycles, every cycle compared against a behavioural model.
module tb_i2c_tx_counters;
  import i2c_tx_pkg::*;

  localparam int TX_MOD    = 1 << TX_WIDTH;
  localparam int BURST_MAX = (1 << BURST_WIDTH) - 1;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   tx_reset = 1'b0;
  logic                   tx_inc = 1'b0;
  logic [TX_WIDTH-1:0]    tx_count;
  logic                   burst_reset = 1'b0;
  logic                   burst_inc = 1'b0;
  logic [BURST_WIDTH-1:0] burst_count;

  int total_checks = 0;
  int fail_checks  = 0;

  // Behavioural model state.
  int m_tx    = 0;
  int m_burst = 0;
  bit m_prev  = 1'b0;

  always #5 clk = ~clk;

  i2c_tx_counters dut (
    .clk         (clk),
    .rst         (rst),
    .tx_reset    (tx_reset),
    .tx_inc      (tx_inc),
    .tx_count    (tx_count),
    .burst_reset (burst_reset),
    .burst_inc   (burst_inc),
    .burst_count (burst_count)
  );

  task automatic check(input string tag, input logic [5:0] obs, input int exp);
    total_checks++;
    assert (obs === 6'(exp))
    else begin
      fail_checks++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model by the same rules, then
  // compare both outputs away from the clock edge.
  task automatic cyc(input bit r, input bit txr, input bit txi,
                     input bit br, input bit bi);
    rst = r; tx_reset = txr; tx_inc = txi; burst_reset = br; burst_inc = bi;
    @(posedge clk);
    if (r) begin
      m_tx = 0; m_burst = 0; m_prev = 1'b0;
    end else begin
      if (txr)      m_tx = 0;
      else if (txi) m_tx = (m_tx + 1) % TX_MOD;
      if (br)                   m_burst = 0;
      else if (bi && !m_prev)   m_burst = (m_burst < BURST_MAX) ? m_burst + 1 : BURST_MAX;
      m_prev = bi;
    end
    #1;
    check("model_tx", tx_count, m_tx);
    check("model_burst", burst_count, m_burst);
  endtask

  initial begin
    // 1. Reset and level count.
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    check("reset_tx", tx_count, 0);
    check("reset_burst", burst_count, 0);
    for (int i = 1; i <= 7; i++) begin
      cyc(0, 0, 1, 0, 0);
      check("level_step", tx_count, i);
    end
    cyc(0, 0, 0, 0, 0);
    check("hold_7", tx_count, ADDR_BITS);

    // 2. Clear beats increment.
    cyc(0, 1, 0, 0, 0);
    repeat (5) cyc(0, 0, 1, 0, 0);
    check("preload_5", tx_count, 5);
    cyc(0, 1, 1, 0, 0);
    check("clear_prio", tx_count, 0);
    cyc(0, 0, 1, 0, 0);
    check("after_clear", tx_count, 1);

    // 3. Wrap-around at 63.
    cyc(0, 1, 0, 0, 0);
    repeat (62) cyc(0, 0, 1, 0, 0);
    check("preload_62", tx_count, 62);
    cyc(0, 0, 1, 0, 0);
    check("wrap_63", tx_count, 63);
    cyc(0, 0, 1, 0, 0);
    check("wrap_0", tx_count, 0);
    cyc(0, 0, 1, 0, 0);
    check("wrap_1", tx_count, 1);

    // 4. Burst edge counting.
    repeat (5) begin
      cyc(0, 0, 0, 0, 1);
      check("burst_held", burst_count, 1);
    end
    cyc(0, 0, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 1);
    check("burst_len", burst_count, BURST_LEN);

    // 5. Burst reset discards a coincident edge.
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1);
    check("burst_clr_edge", burst_count, 0);
    repeat (3) begin
      cyc(0, 0, 0, 0, 1);
      check("burst_no_defer", burst_count, 0);
    end

    // 6. Saturation, then reset mid-operation.
    cyc(0, 0, 0, 0, 0);
    repeat (65) begin
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0);
    end
    check("burst_sat", burst_count, 63);
    cyc(0, 0, 1, 0, 0);
    cyc(1, 0, 1, 0, 0);
    check("midop_rst_tx", tx_count, 0);
    check("midop_rst_burst", burst_count, 0);
    cyc(0, 0, 1, 0, 0);
    check("resume_tx", tx_count, 1);

    // burst_inc already high when reset releases counts as an edge.
    cyc(1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    check("edge_after_rst", burst_count, 1);

    // Random traffic on both counters.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(99) == 0),
          ($urandom_range(19) == 0),
          ($urandom_range(3) != 0),
          ($urandom_range(49) == 0),
          ($urandom_range(1) == 0));
    end

    $display("%0d/%0d checks passed", total_checks - fail_checks, total_checks);
    $finish;
  end

endmodule : tb_i2c_tx_counters

// File: doc/i2c_tx_counters.md
Name: i2c_tx_counters

Overview:
- Pair of synchronous up-counters serving the I2C double-buffered transmit controller.
- The bit counter (tx_count) counts bits shifted out of the active TX buffer; the controller compares it against 7 (address phase) and 8/15 (data phases) and tests byte boundaries (count mod 8).
- The burst counter (burst_count) counts completed data bytes in a burst; the controller compares it against its burst limit (2) to decide when to send STOP.

Parameters:
- TX_WIDTH, 6, width of tx_count.
- BURST_WIDTH, 6, width of burst_count.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset; clears both counters and the edge-detect register.
- tx_reset  input  1  synchronous clear of tx_count (controller ResetTXCount).
- tx_inc  input  1  level increment enable for tx_count (controller IncTXCount).
- tx_count  output  TX_WIDTH  current bit count, registered.
- burst_reset  input  1  synchronous clear of burst_count (controller ResetBurstCnt).
- burst_inc  input  1  increment request for burst_count (controller IncBurstCnt), may be held high many cycles.
- burst_count  output  BURST_WIDTH  current burst byte count, registered.

Behaviour:
- Reset values: tx_count = 0, burst_count = 0, internal burst_inc_d = 0.
- All updates occur on rising clk. There is no combinational path from any input to any output. An input sampled at edge N is visible on the output after edge N.

tx_count:
- Priority is rst > tx_reset > tx_inc.
- rst=1 or tx_reset=1: tx_count <= 0, regardless of tx_inc.
- tx_inc=1 (no clear): tx_count <= tx_count + 1 on every cycle tx_inc is high. This is level-sensitive, one count per clock.
- Wrap-around: at 2^TX_WIDTH-1 (63), an increment gives 0. Modulo arithmetic, no saturation.
- Otherwise tx_count holds.

burst_count:
- Edge-counted: burst_inc_d <= burst_inc every cycle, including during burst_reset; rst clears it to 0.
- Increment only on a detected rising edge (burst_inc=1 and burst_inc_d=0). This gives exactly one count per request however long burst_inc is held.
- Priority is rst > burst_reset > rising edge.
- burst_reset=1: burst_count <= 0. A rising edge in the same cycle is discarded, not deferred.
- Saturation: at 2^BURST_WIDTH-1 (63), further edges leave the value at 63.
- If burst_inc is already high when rst deasserts, the first cycle after reset counts as a rising edge (burst_inc_d=0).

Independence and reset:
- The two counters are fully independent. Simultaneous activity on both is legal.
- Reset mid-operation clears both counters in the same cycle. Counting resumes on the first cycle rst=0.

Decomposition:
- Shared package i2c_tx_pkg holds the constants TX_WIDTH=6, BURST_WIDTH=6, ADDR_BITS=7, BYTE_BITS=8, BURST_LEN=2. The last three are used by the controller and the bench.
- One natural sub-module, i2c_up_counter, parameterized by:
  - WIDTH
  - EDGE_MODE (0 = level increment, 1 = rising-edge increment)
  - SATURATE (0 = wrap, 1 = saturate)
- Instantiate it twice: tx with EDGE_MODE=0, SATURATE=0; burst with EDGE_MODE=1, SATURATE=1.

Test Plan:
1. Reset and level count: rst=1 for 2 cycles -> both outputs 0. Then tx_inc=1 for 7 cycles -> tx_count steps 1..7, one per edge. Drop tx_inc -> holds 7.
2. Clear priority: tx_count=5, assert tx_reset and tx_inc together for 1 cycle -> tx_count=0. Next cycle tx_inc only -> 1.
3. Wrap: preload to 62 by counting, tx_inc=1 for 3 cycles -> 63, 0, 1.
4. Burst edge counting: hold burst_inc=1 for 5 cycles -> burst_count goes 0->1 once and stays 1. Low 1 cycle, high 3 cycles -> 2. Value equals BURST_LEN.
5. Burst reset with a coincident edge: burst_count=2, burst_inc rises in the same cycle burst_reset=1 -> burst_count=0. Keeping burst_inc high afterward -> stays 0.
6. Burst saturation and mid-op reset: generate 65 edges -> burst_count=63. Then rst=1 for 1 cycle while tx_inc=1 -> both outputs 0. tx_count counts again from 1 next cycle.
